control_parquimetro: RTL and testbench

Upstream control stage for the parking-meter credit counter (`contadorBinarioUniversal`, 8-bit). It takes raw coin and clear buttons plus the free-running clock, and converts them into the counter's `en`/`up`/`syn_clr`/`load`/`d` command stream. It also consumes the counter's `max_tick`/`min_tick` flags so credit saturates at full scale and never underflows. Credit is in minutes: each accepted coin adds its value, and one minute is deducted per prescaler period.

---
 rtl/control_parquimetro.sv | 157 +++++++++++++++
 tb/tb_control_parquimetro.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/control_parquimetro.sv
// Control stage for the parking-meter credit counter: turns raw coin/clear/preset
// buttons and a minute prescaler into en/up/syn_clr/load commands for the counter.
module control_parquimetro #(
    parameter int unsigned N             = 8,
    parameter int unsigned COIN_A_MIN    = 15,
    parameter int unsigned COIN_B_MIN    = 60,
    parameter int unsigned PRESET_MIN    = 120,
    parameter logic [31:0] TICKS_PER_MIN = 32'd3_000_000_000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         coin_a,
    input  logic         coin_b,
    input  logic         clear,
    input  logic         preset,
    input  logic         max_tick,
    input  logic         min_tick,
    output logic         en,
    output logic         up,
    output logic         syn_clr,
    output logic         load,
    output logic [N-1:0] d,
    output logic         busy,
    output logic         expired,
    output logic [2:0]   state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADD  = 3'd1,
        S_DEC  = 3'd2,
        S_CLR  = 3'd3,
        S_LOAD = 3'd4
    } state_t;

    state_t       state;
    logic [3:0]   sync1, sync2, prev, pulse;
    logic [31:0]  presc;
    logic         presc_wrap;
    logic         dec_pending;
    logic [N-1:0] rem;
    logic         up_q, syn_clr_q, load_q;

    logic coin_a_pulse, coin_b_pulse, clear_pulse, preset_pulse;
    assign coin_a_pulse = pulse[0];
    assign coin_b_pulse = pulse[1];
    assign clear_pulse  = pulse[2];
    assign preset_pulse = pulse[3];

    // Two-flop synchronizer per button, then a registered rising-edge detector.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
            pulse <= '0;
        end else begin
            sync1 <= {preset, clear, coin_b, coin_a};
            sync2 <= sync1;
            prev  <= sync2;
            pulse <= sync2 & ~prev;
        end
    end

    assign presc_wrap = (presc == TICKS_PER_MIN - 32'd1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc <= '0;
        end else if (presc_wrap) begin
            presc <= '0;
        end else begin
            presc <= presc + 32'd1;
        end
    end

    // One-deep minute request; a strobe landing on the DEC cycle stays queued.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dec_pending <= 1'b0;
        end else if (clear_pulse) begin
            dec_pending <= 1'b0;
        end else if (presc_wrap) begin
            dec_pending <= 1'b1;
        end else if (state == S_DEC) begin
            dec_pending <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            rem       <= '0;
            up_q      <= 1'b0;
            syn_clr_q <= 1'b0;
            load_q    <= 1'b0;
        end else begin
            up_q      <= 1'b0;
            syn_clr_q <= 1'b0;
            load_q    <= 1'b0;
            if (clear_pulse) begin
                state     <= S_CLR;
                syn_clr_q <= 1'b1;
            end else if (preset_pulse && state != S_ADD) begin
                state  <= S_LOAD;
                load_q <= 1'b1;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (coin_a_pulse) begin
                            state <= S_ADD;
                            rem   <= COIN_A_MIN[N-1:0];
                            up_q  <= 1'b1;
                        end else if (coin_b_pulse) begin
                            state <= S_ADD;
                            rem   <= COIN_B_MIN[N-1:0];
                            up_q  <= 1'b1;
                        end else if (dec_pending) begin
                            state <= S_DEC;
                        end
                    end
                    S_ADD: begin
                        if (!max_tick) begin
                            rem <= rem - 1'b1;
                        end
                        // Full scale reached: leftover credit is discarded.
                        if (max_tick || rem == 1) begin
                            state <= S_IDLE;
                        end else begin
                            up_q <= 1'b1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    // en must react to the counter flags in the same cycle to avoid wrap.
    always_comb begin
        en = 1'b0;
        if (state == S_ADD) begin
            en = ~max_tick;
        end else if (state == S_DEC) begin
            en = ~min_tick;
        end
    end

    assign up        = up_q;
    assign syn_clr   = syn_clr_q;
    assign load      = load_q;
    assign d         = PRESET_MIN[N-1:0];
    assign busy      = (state != S_IDLE);
    assign expired   = (state == S_IDLE) && min_tick;
    assign state_dbg = state;

endmodule

// File: tb/tb_control_parquimetro.sv
// Directed bench for control_parquimetro driving a behavioural 8-bit credit counter.
module tb_control_parquimetro;

    logic       clk;
    logic       reset;
    logic       coin_a, coin_b, clear, preset;
    logic       max_tick, min_tick;
    logic       en, up, syn_clr, load, busy, expired;
    logic [7:0] d;
    logic [2:0] state_dbg;

    logic [7:0] q;
    logic       tb_set;
    logic [7:0] tb_val;

    int total;
    int bad;
    int en_up_n, en_dn_n, busy_n, syn_n, load_n;

    control_parquimetro #(
        .N(8), .COIN_A_MIN(3), .COIN_B_MIN(5), .PRESET_MIN(250), .TICKS_PER_MIN(32'd40)
    ) dut (
        .clk(clk), .reset(reset),
        .coin_a(coin_a), .coin_b(coin_b), .clear(clear), .preset(preset),
        .max_tick(max_tick), .min_tick(min_tick),
        .en(en), .up(up), .syn_clr(syn_clr), .load(load), .d(d),
        .busy(busy), .expired(expired), .state_dbg(state_dbg)
    );

    // clock/reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counter being controlled; tb_set lets the bench seed a starting credit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)        q <= 8'd0;
        else if (tb_set)   q <= tb_val;
        else if (syn_clr)  q <= 8'd0;
        else if (load)     q <= d;
        else if (en)       q <= up ? q + 8'd1 : q - 8'd1;
    end
    assign max_tick = (q == 8'hFF);
    assign min_tick = (q == 8'h00);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clr_counts();
        en_up_n = 0; en_dn_n = 0; busy_n = 0; syn_n = 0; load_n = 0;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        if (en && up)  en_up_n++;
        if (en && !up) en_dn_n++;
        if (busy)      busy_n++;
        if (syn_clr)   syn_n++;
        if (load)      load_n++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic reset_dut();
        reset = 1'b0;
        coin_a = 1'b0; coin_b = 1'b0; clear = 1'b0; preset = 1'b0;
        tb_set = 1'b0; tb_val = 8'd0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic seed_q(input logic [7:0] v);
        tb_set = 1'b1;
        tb_val = v;
        step();
        tb_set = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0;
        coin_a = 1'b0; coin_b = 1'b0; clear = 1'b0; preset = 1'b0;
        tb_set = 1'b0; tb_val = 8'd0;
        clr_counts();

        // Outputs while held in reset
        repeat (2) @(negedge clk);
        check_eq("rst_en", en, 0);
        check_eq("rst_up", up, 0);
        check_eq("rst_syn_clr", syn_clr, 0);
        check_eq("rst_load", load, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_d", d, 250);
        check_eq("rst_expired", expired, 1);
        check_eq("rst_state", state_dbg, 0);

        // coin_a adds 3
        reset_dut();
        coin_a = 1'b1;
        clr_counts();
        run(12);
        check_eq("coin_a_en_up", en_up_n, 3);
        check_eq("coin_a_busy", busy_n, 3);
        check_eq("coin_a_q", q, 3);
        check_eq("coin_a_expired", expired, 0);
        check_eq("coin_a_state", state_dbg, 0);

        // Saturation from 252 with coin_b
        reset_dut();
        seed_q(8'd252);
        coin_b = 1'b1;
        clr_counts();
        run(15);
        check_eq("sat_en_up", en_up_n, 3);
        check_eq("sat_busy", busy_n, 4);
        check_eq("sat_q", q, 255);
        check_eq("sat_state", state_dbg, 0);

        // Minute decrements from q=2, no underflow
        reset_dut();
        seed_q(8'd2);
        clr_counts();
        run(59);
        check_eq("dec1_q", q, 1);
        check_eq("dec1_en_dn", en_dn_n, 1);
        run(30);
        check_eq("dec2_q", q, 0);
        clr_counts();
        run(60);
        check_eq("dec3_en", en_up_n + en_dn_n, 0);
        check_eq("dec3_busy", busy_n, 1);
        check_eq("dec3_q", q, 0);
        check_eq("dec3_expired", expired, 1);

        // Strobe during coin_b ADD, extra coin ignored
        reset_dut();
        seed_q(8'd10);
        run(33);
        coin_b = 1'b1;
        step();
        coin_a = 1'b1;
        clr_counts();
        run(25);
        check_eq("strobe_en_up", en_up_n, 5);
        check_eq("strobe_en_dn", en_dn_n, 1);
        check_eq("strobe_q", q, 14);

        // clear mid-ADD, held clear, pending minute dropped
        reset_dut();
        seed_q(8'd20);
        run(34);
        coin_b = 1'b1;
        clr_counts();
        run(2);
        clear = 1'b1;
        run(38);
        check_eq("clr_en_up", en_up_n, 2);
        check_eq("clr_syn_clr", syn_n, 1);
        check_eq("clr_busy", busy_n, 3);
        check_eq("clr_q", q, 0);
        check_eq("clr_dec_en", en_dn_n, 0);

        // preset
        reset_dut();
        preset = 1'b1;
        clr_counts();
        run(12);
        check_eq("preset_load", load_n, 1);
        check_eq("preset_q", q, 250);
        check_eq("preset_d", d, 250);

        // reset mid-ADD
        reset_dut();
        coin_b = 1'b1;
        run(5);
        check_eq("midadd_busy", busy, 1);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_eq("async_en", en, 0);
        check_eq("async_up", up, 0);
        check_eq("async_busy", busy, 0);
        check_eq("async_state", state_dbg, 0);
        coin_b = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        run(5);
        check_eq("post_rst_busy", busy_n >= 0 ? busy : 1'b1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
